// File: rtl/battleship_nios2_qsys_0_ocimem_arbiter_if.sv
// CPU-side debug Avalon slave bus of the OCI memory arbiter.
// The slave modport is the arbiter side; the master modport is the CPU side.
interface battleship_nios2_qsys_0_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/battleship_nios2_qsys_0_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG debug commands and the CPU debug
// slave, with fixed JTAG priority bounded by a CPU anti-starvation count.
module battleship_nios2_qsys_0_ocimem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_JTAG = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  battleship_nios2_qsys_0_ocimem_arbiter_if.slave avs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  localparam int SW = $clog2(MAX_JTAG + 1);

  typedef enum logic [2:0] {IDLE, JWR, JRD, JRD_DATA, CWR, CRD, CRD_DATA} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_READ, OP_WRITE} jop_t;

  state_t            state, state_nx;
  jop_t              jop, new_op, grant_op;
  logic              jtag_pend;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0]       jtag_wdata;
  logic [31:0]       readdata_q;
  logic [SW-1:0]     starve_cnt;

  logic cpu_req, strobe, accept, jtag_req, starved;
  logic jtag_grant, cpu_grant, jtag_done;
  logic jdo_unused;

  assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

  assign cpu_req = avs.avs_read | avs.avs_write;
  assign strobe  = take_action_ocimem_a | take_action_ocimem_b;
  assign accept  = strobe & ~jtag_pend;
  assign new_op  = take_action_ocimem_a ? (jdo[35] ? OP_READ : OP_LOAD) : OP_WRITE;

  // A strobe accepted this cycle may be granted immediately; its fields are captured on
  // the same edge that enters JWR/JRD, so the op state always sees the latched copy.
  assign grant_op = jtag_pend ? jop : new_op;
  assign jtag_req = jtag_pend ? (jop != OP_LOAD) : (accept && new_op != OP_LOAD);
  assign starved  = cpu_req && (starve_cnt == SW'(MAX_JTAG));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    jtag_grant = 1'b0;
    cpu_grant  = 1'b0;
    jtag_done  = 1'b0;
    ram_wren   = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        if (jtag_req && !starved) begin
          jtag_grant = 1'b1;
          state_nx   = (grant_op == OP_WRITE) ? JWR : JRD;
        end else if (cpu_req) begin
          cpu_grant = 1'b1;
          state_nx  = avs.avs_write ? CWR : CRD;
        end
      end
      JWR: begin
        ram_wren  = 1'b1;
        ram_addr  = jtag_addr;
        ram_wdata = DATA_W'(jtag_wdata);
        jtag_done = 1'b1;
        state_nx  = IDLE;
      end
      JRD: begin
        ram_addr = jtag_addr;
        state_nx = JRD_DATA;
      end
      JRD_DATA: begin
        jtag_done = 1'b1;
        state_nx  = IDLE;
      end
      CWR: begin
        ram_wren  = 1'b1;
        ram_addr  = avs.avs_address;
        ram_wdata = DATA_W'(avs.avs_writedata);
        state_nx  = IDLE;
      end
      CRD: begin
        ram_addr = avs.avs_address;
        state_nx = CRD_DATA;
      end
      CRD_DATA: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    avs.avs_waitrequest = cpu_req && !(state == CWR || state == CRD_DATA);
    // Read data is passed through in the one cycle waitrequest is low, then held.
    avs.avs_readdata    = (state == CRD_DATA) ? 32'(ram_rdata) : readdata_q;
    monitor_ready       = ~jtag_pend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_pend    <= 1'b0;
      jop          <= OP_LOAD;
      jtag_addr    <= '0;
      jtag_wdata   <= '0;
      jtag_overrun <= 1'b0;
      MonDReg      <= '0;
      readdata_q   <= '0;
      starve_cnt   <= '0;
    end else begin
      if (accept) begin
        jtag_pend  <= 1'b1;
        jop        <= new_op;
        jtag_wdata <= jdo[34:3];
        if (take_action_ocimem_a) jtag_addr <= jdo[ADDR_W+16:17];
      end
      if ((strobe && jtag_pend) || (take_action_ocimem_a && take_action_ocimem_b))
        jtag_overrun <= 1'b1;
      if (jtag_done || (jtag_pend && jop == OP_LOAD)) jtag_pend <= 1'b0;
      if (state == JWR || state == JRD_DATA) jtag_addr <= jtag_addr + 1'b1;
      if (state == JRD_DATA) MonDReg <= 32'(ram_rdata);
      if (state == CRD_DATA) readdata_q <= 32'(ram_rdata);
      if (jtag_grant && cpu_req) starve_cnt <= starve_cnt + 1'b1;
      else if (cpu_grant)        starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_battleship_nios2_qsys_0_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter with a registered single-port RAM model.
module tb_battleship_nios2_qsys_0_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_a, take_b;
  logic [37:0] jdo;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256] = '{default: '0};
  logic [31:0] wr_log [64];
  int          wr_cnt = 0;

  battleship_nios2_qsys_0_ocimem_arbiter_if #(.ADDR_W(8)) avs_bus ();

  battleship_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_JTAG(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .jdo                  (jdo),
    .avs                  (avs_bus),
    .ram_addr             (ram_addr),
    .ram_wren             (ram_wren),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .jtag_overrun         (jtag_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr]  <= ram_wdata;
      wr_log[wr_cnt] <= ram_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    return {2'b00, rd, 10'd0, a, 17'd0};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  task automatic strobe_a(input logic [7:0] a, input logic rd);
    take_a = 1'b1; jdo = jdo_a(a, rd);
    step();
    take_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    take_b = 1'b1; jdo = jdo_b(d);
    step();
    take_b = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!monitor_ready && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(monitor_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nj;
    logic cpu_done;

    reset_n = 1'b0; take_a = 1'b0; take_b = 1'b0; jdo = '0;
    avs_bus.avs_address = '0; avs_bus.avs_read = 1'b0;
    avs_bus.avs_write = 1'b0; avs_bus.avs_writedata = '0;
    #3;
    check("rst_wren",     32'(ram_wren), 32'd0);
    check("rst_addr",     32'(ram_addr), 32'd0);
    check("rst_mondreg",  MonDReg, 32'd0);
    check("rst_readdata", avs_bus.avs_readdata, 32'd0);
    check("rst_waitreq",  32'(avs_bus.avs_waitrequest), 32'd0);
    check("rst_ready",    32'(monitor_ready), 32'd1);
    check("rst_overrun",  32'(jtag_overrun), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // 1: CPU write then read back
    avs_bus.avs_address = 8'h10; avs_bus.avs_writedata = 32'hDEADBEEF; avs_bus.avs_write = 1'b1;
    #1;
    check("t1_wr_wait_idle", 32'(avs_bus.avs_waitrequest), 32'd1);
    step();
    check("t1_wr_wait_c1", 32'(avs_bus.avs_waitrequest), 32'd0);
    check("t1_wr_wren",    32'(ram_wren), 32'd1);
    check("t1_wr_addr",    32'(ram_addr), 32'h10);
    avs_bus.avs_write = 1'b0;
    step();
    avs_bus.avs_read = 1'b1;
    step();
    check("t1_rd_wait_c1", 32'(avs_bus.avs_waitrequest), 32'd1);
    check("t1_rd_nowren",  32'(ram_wren), 32'd0);
    step();
    check("t1_rd_wait_c2", 32'(avs_bus.avs_waitrequest), 32'd0);
    check("t1_rd_data",    avs_bus.avs_readdata, 32'hDEADBEEF);
    avs_bus.avs_read = 1'b0;
    step();
    check("t1_ready",   32'(monitor_ready), 32'd1);
    check("t1_overrun", 32'(jtag_overrun), 32'd0);

    // 2: JTAG load, two writes with wrap, JTAG read
    strobe_a(8'hFE, 1'b0);
    #1;
    check("t2_load_busy", 32'(monitor_ready), 32'd0);
    wait_ready("t2_load_ready");
    strobe_b(32'h11111111);
    #1;
    check("t2_wr_busy", 32'(monitor_ready), 32'd0);
    wait_ready("t2_wr1_ready");
    strobe_b(32'h22222222);
    wait_ready("t2_wr2_ready");
    check("t2_mem_fe", mem[8'hFE], 32'h11111111);
    check("t2_mem_ff", mem[8'hFF], 32'h22222222);
    strobe_b(32'h33333333);
    wait_ready("t2_wr3_ready");
    check("t2_wrap_mem_00", mem[8'h00], 32'h33333333);
    strobe_a(8'hFE, 1'b1);
    wait_ready("t2_rd_ready");
    check("t2_mondreg", MonDReg, 32'h11111111);
    check("t2_overrun", 32'(jtag_overrun), 32'd0);

    // 3: contention with JTAG continuously pending
    base = wr_cnt; nj = 0; cpu_done = 1'b0;
    avs_bus.avs_address = 8'h20; avs_bus.avs_writedata = 32'hC0C0C0C0; avs_bus.avs_write = 1'b1;
    for (int i = 0; i < 40 && !cpu_done; i++) begin
      take_b = monitor_ready;
      jdo    = jdo_b(32'h30000000 + 32'(nj));
      if (monitor_ready) nj++;
      #1;
      if (!avs_bus.avs_waitrequest) cpu_done = 1'b1;
      step();
      take_b = 1'b0;
    end
    avs_bus.avs_write = 1'b0;
    check("t3_cpu_served", 32'(cpu_done), 32'd1);
    wait_ready("t3_tail_ready");
    check("t3_nwrites",  32'(wr_cnt - base), 32'd6);
    check("t3_first_j",  wr_log[base],     32'h30000000);
    check("t3_j4",       wr_log[base + 3], 32'h30000003);
    check("t3_cpu_5th",  wr_log[base + 4], 32'hC0C0C0C0);
    check("t3_j_after",  wr_log[base + 5], 32'h30000004);
    check("t3_mem_20",   mem[8'h20], 32'hC0C0C0C0);

    // 4: second b while first pending
    strobe_a(8'h40, 1'b0);
    wait_ready("t4_load_ready");
    check("t4_overrun_pre", 32'(jtag_overrun), 32'd0);
    base = wr_cnt;
    take_b = 1'b1; jdo = jdo_b(32'h44444444);
    step();
    jdo = jdo_b(32'h55555555);
    step();
    take_b = 1'b0;
    wait_ready("t4_ready");
    step();
    check("t4_overrun",  32'(jtag_overrun), 32'd1);
    check("t4_nwrites",  32'(wr_cnt - base), 32'd1);
    check("t4_mem_40",   mem[8'h40], 32'h44444444);
    check("t4_mem_41",   mem[8'h41], 32'h0);

    // 5a: reset during CRD
    avs_bus.avs_address = 8'h10; avs_bus.avs_read = 1'b1;
    step();
    check("t5_crd_wait", 32'(avs_bus.avs_waitrequest), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5a_wren",     32'(ram_wren), 32'd0);
    check("t5a_addr",     32'(ram_addr), 32'd0);
    check("t5a_readdata", avs_bus.avs_readdata, 32'd0);
    check("t5a_mondreg",  MonDReg, 32'd0);
    check("t5a_overrun",  32'(jtag_overrun), 32'd0);
    check("t5a_ready",    32'(monitor_ready), 32'd1);
    check("t5a_wait_req", 32'(avs_bus.avs_waitrequest), 32'd1);
    avs_bus.avs_read = 1'b0;
    #1;
    check("t5a_wait_noreq", 32'(avs_bus.avs_waitrequest), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // 5b: reset during JWR
    strobe_a(8'h50, 1'b0);
    wait_ready("t5b_load_ready");
    base = wr_cnt;
    strobe_b(32'h66666666);
    check("t5b_jwr_active", 32'(ram_wren), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5b_wren",  32'(ram_wren), 32'd0);
    check("t5b_addr",  32'(ram_addr), 32'd0);
    check("t5b_ready", 32'(monitor_ready), 32'd1);
    step();
    reset_n = 1'b1;
    step();
    check("t5b_nwrites", 32'(wr_cnt - base), 32'd0);
    check("t5b_mem_50",  mem[8'h50], 32'h0);

    // a and b in the same cycle: a taken, b dropped
    base = wr_cnt;
    take_a = 1'b1; take_b = 1'b1; jdo = jdo_a(8'h60, 1'b0);
    step();
    take_a = 1'b0; take_b = 1'b0;
    wait_ready("t5c_ready");
    check("t5c_overrun", 32'(jtag_overrun), 32'd1);
    check("t5c_nwrites", 32'(wr_cnt - base), 32'd0);
    strobe_b(32'h77777777);
    wait_ready("t5c_wr_ready");
    check("t5c_mem_60", mem[8'h60], 32'h77777777);

    // 6: read and write together act as a write
    avs_bus.avs_address = 8'h05; avs_bus.avs_writedata = 32'hA5A5A5A5;
    avs_bus.avs_read = 1'b1; avs_bus.avs_write = 1'b1;
    step();
    check("t6_wait_c1", 32'(avs_bus.avs_waitrequest), 32'd0);
    check("t6_wren",    32'(ram_wren), 32'd1);
    avs_bus.avs_write = 1'b0; avs_bus.avs_read = 1'b0;
    step();
    check("t6_mem_05", mem[8'h05], 32'hA5A5A5A5);
    avs_bus.avs_read = 1'b1;
    step();
    step();
    check("t6_rd_wait", 32'(avs_bus.avs_waitrequest), 32'd0);
    check("t6_rd_data", avs_bus.avs_readdata, 32'hA5A5A5A5);
    avs_bus.avs_read = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
